fir_tap_bank: RTL and testbench
===============================

Name: fir_tap_bank

Overview:
Receiving end of the serial tap-load interface (i_tap_wr / i_tap) that the filter control FSM drives from the coefficient memory. It captures one tap per write strobe into an indexed register bank, tracks load progress and flags a completed load. It also detects over-length loads and provides a registered readback port plus a running signed checksum, so software and benches can confirm the coefficients the FIR actually holds.

Parameters:
NTAPS, 16, number of tap registers / writes that make a complete load
TW, 16, tap width in bits (signed two's complement)
IW, $clog2(NTAPS) = 4, index width

Ports:
i_clk  in  1  clock, all logic on rising edge
i_reset  in  1  asynchronous, active-low reset
i_tap_wr  in  1  active-high write strobe; one tap accepted per cycle it is high
i_tap  in  TW  tap value, valid when i_tap_wr=1
i_clear  in  1  synchronous clear; drops the current load and zeroes the bank
i_rd_idx  in  IW  readback index
o_rd_tap  out  TW  registered readback data
o_wr_cnt  out  IW+1  number of taps accepted since the last clear/reset (0..NTAPS)
o_busy  out  1  load in progress (state LOADING)
o_loaded  out  1  full load complete (state FULL)
o_ovf  out  1  sticky flag: a write arrived while in FULL
o_sum  out  TW+IW  signed sum of all accepted taps

Behaviour:
- Reset (i_reset=0, asynchronous assert, synchronous release): state EMPTY, write pointer 0, all taps 0, o_rd_tap=0, o_wr_cnt=0, o_busy=0, o_loaded=0, o_ovf=0, o_sum=0.
- State machine: EMPTY, LOADING, FULL.
  - EMPTY to LOADING on the first write. If NTAPS=1, the first write goes straight to FULL.
  - LOADING to FULL on the write that makes the count reach NTAPS.
  - FULL is held until i_clear or reset.
- Write (i_tap_wr=1, not FULL, no i_clear):
  - tap[wr_ptr] <= i_tap
  - wr_ptr++ and o_wr_cnt++
  - o_sum <= o_sum + sign-extended i_tap
  - All updates are visible the cycle after the strobe edge.
- Gaps: i_tap_wr may drop for any number of cycles while LOADING. The state and pointer hold, and loading resumes at the next index. No timeout.
- Overflow: a write while in FULL is discarded. Taps, count and sum are unchanged, and o_ovf is set the next cycle. o_ovf stays set until i_clear or reset.
- i_clear:
  - Next cycle: EMPTY, pointer 0, count 0, all taps 0, sum 0, ovf 0, o_rd_tap 0.
  - i_clear has priority over a simultaneous i_tap_wr, and that write is lost.
- Readback:
  - o_rd_tap <= tap[i_rd_idx], one-cycle latency, in every state.
  - Index >= NTAPS returns 0.
  - Read and write to the same index in the same cycle returns the old value.
- Arithmetic: o_sum is signed, TW+IW bits. It cannot overflow within NTAPS writes (-2^(TW-1)*NTAPS fits exactly). No saturation logic.
- o_busy and o_loaded are registered, decoded from state, and mutually exclusive.

Decomposition:
- Package fir_pkg:
  - constants NTAPS, TW, IW
  - tap_t (logic signed [TW-1:0])
  - sum_t (logic signed [TW+IW-1:0])
  - enum tapbank_state_t {EMPTY, LOADING, FULL}
- Single module; no sub-module is natural. The bank is a plain register array, not a RAM, so that clear-to-zero works in one cycle.

Test Plan:
- Contiguous load: reset, then 16 back-to-back writes of 1..16 -> o_busy high cycles 1..15 after the first write; o_loaded=1 the cycle after the 16th write; o_wr_cnt=16; o_sum=136; i_rd_idx=5 gives o_rd_tap=6 one cycle later.
- Overflow: after the load above, write 0x7FFF -> o_ovf=1 next cycle; tap[0] reads 1; o_sum stays 136; o_wr_cnt stays 16; o_ovf persists until i_clear.
- Gapped load: 8 writes of 0x0010, 5 idle cycles (o_busy=1, o_wr_cnt=8), then 8 writes of 0xFFF0 -> o_loaded=1; o_sum=0; tap[8] reads 0xFFF0.
- Negative extreme: 16 writes of 0x8000 -> o_sum = -524288 (20'h80000); no wrap.
- Clear collision: at o_wr_cnt=7, assert i_clear and i_tap_wr together with i_tap=0x1234 -> next cycle EMPTY, count 0, o_sum 0, all indices read 0.
- Async reset mid-load: after 10 writes, pull i_reset low between clock edges -> all outputs 0 immediately without a clock edge; after release, a fresh 16-write load completes normally.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR tap bank.
// Widths are derived from NTAPS/TW so the bank and its sum always stay consistent.
package fir_pkg;

  localparam int NTAPS = 16;
  localparam int TW    = 16;
  localparam int IW    = $clog2(NTAPS);
  localparam int SW    = TW + IW;

  typedef logic signed [TW-1:0] tap_t;
  typedef logic signed [SW-1:0] sum_t;
  typedef logic        [IW-1:0] idx_t;
  typedef logic        [IW:0]   cnt_t;

  typedef enum logic [1:0] {
    EMPTY,
    LOADING,
    FULL
  } tapbank_state_t;

  localparam cnt_t CNT_FULL = cnt_t'(NTAPS);

  // A size cast of a signed operand sign-extends into the wider sum.
  function automatic sum_t tap_ext(input tap_t t);
    return sum_t'(t);
  endfunction

endpackage

// File: rtl/fir_tap_bank_if.sv
// Tap-load, clear and readback signals between the filter control FSM and the tap bank.
// The master drives strobes and indices; the slave returns status, readback data and checksum.
interface fir_tap_bank_if;
  import fir_pkg::*;

  logic i_tap_wr;
  tap_t i_tap;
  logic i_clear;
  idx_t i_rd_idx;
  tap_t o_rd_tap;
  cnt_t o_wr_cnt;
  logic o_busy;
  logic o_loaded;
  logic o_ovf;
  sum_t o_sum;

  modport master (
    output i_tap_wr, i_tap, i_clear, i_rd_idx,
    input  o_rd_tap, o_wr_cnt, o_busy, o_loaded, o_ovf, o_sum
  );

  modport slave (
    input  i_tap_wr, i_tap, i_clear, i_rd_idx,
    output o_rd_tap, o_wr_cnt, o_busy, o_loaded, o_ovf, o_sum
  );

endinterface

// File: rtl/fir_tap_bank.sv
// Indexed tap register bank with load tracking, sticky overflow, registered readback and checksum.
// All effects of a strobe or clear appear one cycle later; no backpressure, writes in FULL are dropped.
module fir_tap_bank
  import fir_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  fir_tap_bank_if.slave   bus
);

  tapbank_state_t state_q, state_d;
  cnt_t           cnt_q, cnt_d;
  tap_t           taps_q [NTAPS];
  tap_t           taps_d [NTAPS];
  tap_t           rd_tap_q, rd_tap_d;
  sum_t           sum_q, sum_d;
  logic           ovf_q, ovf_d;
  logic           busy_q, busy_d;
  logic           loaded_q, loaded_d;
  idx_t           wr_ptr;

  // The write pointer is the low bits of the count; it only wraps once FULL blocks writes.
  assign wr_ptr = cnt_q[IW-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    taps_d   = taps_q;
    rd_tap_d = rd_tap_q;
    sum_d    = sum_q;
    ovf_d    = ovf_q;

    if (bus.i_clear) begin
      state_d  = EMPTY;
      cnt_d    = '0;
      taps_d   = '{default: '0};
      rd_tap_d = '0;
      sum_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      // Readback samples the bank before this cycle's write lands.
      if ({1'b0, bus.i_rd_idx} < CNT_FULL) begin
        rd_tap_d = taps_q[bus.i_rd_idx];
      end else begin
        rd_tap_d = '0;
      end

      if (bus.i_tap_wr) begin
        if (state_q == FULL) begin
          ovf_d = 1'b1;
        end else begin
          taps_d[wr_ptr] = bus.i_tap;
          cnt_d          = cnt_q + 1'b1;
          sum_d          = sum_q + tap_ext(bus.i_tap);
          state_d        = (cnt_d == CNT_FULL) ? FULL : LOADING;
        end
      end
    end

    busy_d   = (state_d == LOADING);
    loaded_d = (state_d == FULL);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= EMPTY;
      cnt_q    <= '0;
      taps_q   <= '{default: '0};
      rd_tap_q <= '0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      taps_q   <= taps_d;
      rd_tap_q <= rd_tap_d;
      sum_q    <= sum_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      loaded_q <= loaded_d;
    end
  end

  assign bus.o_rd_tap = rd_tap_q;
  assign bus.o_wr_cnt = cnt_q;
  assign bus.o_busy   = busy_q;
  assign bus.o_loaded = loaded_q;
  assign bus.o_ovf    = ovf_q;
  assign bus.o_sum    = sum_q;

endmodule

// File: tb/tb_fir_tap_bank.sv
// Directed and randomized checks of fir_tap_bank against an array-based model of the tap bank.
// Outputs are sampled 1ns after each rising edge; inputs change at that same point.
module tb_fir_tap_bank;
  import fir_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // Reference model: the bank contents, accepted count, overflow flag and last readback.
  logic signed [15:0] mtaps [16];
  int                 mcnt;
  bit                 movf;
  logic signed [15:0] mrd;

  fir_tap_bank_if bus ();

  fir_tap_bank dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint model_sum();
    longint s = 0;
    for (int i = 0; i < 16; i++) s += longint'(mtaps[i]);
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mtaps[i] = '0;
    mcnt = 0;
    movf = 1'b0;
    mrd  = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/cnt"},    longint'(bus.o_wr_cnt), longint'(mcnt));
    chk({tag, "/busy"},   longint'(bus.o_busy),   longint'(mcnt > 0 && mcnt < 16));
    chk({tag, "/loaded"}, longint'(bus.o_loaded), longint'(mcnt == 16));
    chk({tag, "/ovf"},    longint'(bus.o_ovf),    longint'(movf));
    chk({tag, "/sum"},    longint'(bus.o_sum),    model_sum());
    chk({tag, "/rd"},     longint'(bus.o_rd_tap), longint'(mrd));
  endtask

  task automatic cyc(input string tag, input bit wr, input logic [15:0] tap,
                     input bit clr, input logic [3:0] idx);
    bus.i_tap_wr = wr;
    bus.i_tap    = tap;
    bus.i_clear  = clr;
    bus.i_rd_idx = idx;
    @(posedge clk);
    #1;
    if (clr) begin
      model_reset();
    end else begin
      mrd = mtaps[idx];
      if (wr) begin
        if (mcnt == 16) movf = 1'b1;
        else begin
          mtaps[mcnt] = tap;
          mcnt++;
        end
      end
    end
    bus.i_tap_wr = 1'b0;
    bus.i_clear  = 1'b0;
    check_all(tag);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    rst_n        = 1'b0;
    bus.i_tap_wr = 1'b0;
    bus.i_tap    = '0;
    bus.i_clear  = 1'b0;
    bus.i_rd_idx = '0;

    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Contiguous load of 1..16.
    for (int i = 1; i <= 16; i++) cyc("contig", 1'b1, 16'(i), 1'b0, 4'($urandom));
    chk("contig_sum136", longint'(bus.o_sum), 136);
    cyc("rd_idx5", 1'b0, '0, 1'b0, 4'd5);
    chk("rd5_is6", longint'(bus.o_rd_tap), 6);

    // Overflow write is dropped and the flag sticks.
    cyc("ovf_wr", 1'b1, 16'h7FFF, 1'b0, 4'd0);
    chk("ovf_set", longint'(bus.o_ovf), 1);
    cyc("ovf_rd0", 1'b0, '0, 1'b0, 4'd0);
    chk("ovf_tap0", longint'(bus.o_rd_tap), 1);
    for (int i = 0; i < 4; i++) cyc("ovf_hold", 1'b0, '0, 1'b0, 4'($urandom));
    cyc("clear1", 1'b0, '0, 1'b1, 4'($urandom));

    // Gapped load: the state and pointer hold across idle cycles.
    for (int i = 0; i < 8; i++) cyc("gap_a", 1'b1, 16'h0010, 1'b0, 4'($urandom));
    for (int i = 0; i < 5; i++) cyc("gap_idle", 1'b0, '0, 1'b0, 4'($urandom));
    for (int i = 0; i < 8; i++) cyc("gap_b", 1'b1, 16'hFFF0, 1'b0, 4'($urandom));
    chk("gap_sum0", longint'(bus.o_sum), 0);
    cyc("gap_rd8", 1'b0, '0, 1'b0, 4'd8);
    chk("gap_tap8", longint'(bus.o_rd_tap), -16);
    cyc("clear2", 1'b0, '0, 1'b1, 4'($urandom));

    // Most negative taps must not wrap the sum.
    for (int i = 0; i < 16; i++) cyc("neg", 1'b1, 16'h8000, 1'b0, 4'($urandom));
    chk("neg_sum", longint'(bus.o_sum), -524288);
    cyc("clear3", 1'b0, '0, 1'b1, 4'($urandom));

    // Random taps with random gaps up to seven accepted, then clear collides with a write.
    while (mcnt < 7) begin
      if ($urandom_range(0, 2) == 0) cyc("pre7_idle", 1'b0, '0, 1'b0, 4'($urandom));
      else cyc("pre7_wr", 1'b1, 16'($urandom), 1'b0, 4'($urandom));
    end
    cyc("collide", 1'b1, 16'h1234, 1'b1, 4'($urandom));
    chk("collide_cnt", longint'(bus.o_wr_cnt), 0);
    for (int i = 0; i < 16; i++) cyc("zero_rd", 1'b0, '0, 1'b0, 4'(i));

    // Asynchronous reset between edges in the middle of a load.
    for (int i = 0; i < 10; i++) cyc("pre_arst", 1'b1, 16'($urandom), 1'b0, 4'($urandom));
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst_now");
    @(posedge clk);
    #1;
    check_all("arst_hold");
    #2;
    rst_n = 1'b1;
    while (mcnt < 16) begin
      if ($urandom_range(0, 3) == 0) cyc("post_idle", 1'b0, '0, 1'b0, 4'($urandom));
      else cyc("post_wr", 1'b1, 16'($urandom), 1'b0, 4'($urandom));
    end
    chk("post_loaded", longint'(bus.o_loaded), 1);

    // Random soak: writes, overflows, clears and reads in any mix.
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      cyc("soak", r < 70, 16'($urandom), r < 3, 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
